// File: rtl/dffsr_pkg.sv
// Shared constants and cell-kind enumeration for the dffsr flop-variant test structure.
package dffsr_pkg;

  localparam int NUM_CELLS = 6;

  localparam int C_PLAIN     = 0;
  localparam int C_SET       = 1;
  localparam int C_RST       = 2;
  localparam int C_SR_SETPRI = 3;
  localparam int C_SR_RSTPRI = 4;
  localparam int C_EN        = 5;

  typedef enum logic [2:0] {
    K_PLAIN,
    K_SET,
    K_RST,
    K_SR_SETPRI,
    K_SR_RSTPRI,
    K_EN
  } cell_kind_e;

endpackage

// File: rtl/sr_flop.sv
// One 1-bit synchronous flop with optional synchronous set, reset and enable.
module sr_flop #(
  parameter bit HAS_SET = 1'b0,
  parameter bit HAS_RST = 1'b0,
  parameter bit SET_PRI = 1'b1,
  parameter bit HAS_EN  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  input  logic s,
  input  logic r,
  input  logic en,
  output logic q
);

  logic r_q;
  logic w_data;
  logic w_next;

  // Later assignment wins, so the control applied last has priority.
  always_comb begin
    w_data = (HAS_EN && !en) ? r_q : d;
    w_next = w_data;
    if (SET_PRI) begin
      if (HAS_RST && r) w_next = 1'b0;
      if (HAS_SET && s) w_next = 1'b1;
    end else begin
      if (HAS_SET && s) w_next = 1'b1;
      if (HAS_RST && r) w_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_q <= 1'b0;
    else        r_q <= w_next;
  end

  assign q = r_q;

endmodule

// File: rtl/dffsr_top.sv
// Bank of six flop-variant cells checked every cycle against a truth-table golden model.
module dffsr_top
  import dffsr_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  output logic b
);

  logic                 r_a_q;
  logic [NUM_CELLS-1:0] r_gold;
  logic [NUM_CELLS-1:0] w_gold_d;
  logic [NUM_CELLS-1:0] w_cell_q;
  logic                 w_match;
  logic                 r_b;
  logic                 w_q_c0, w_q_c1, w_q_c2, w_q_c3, w_q_c4, w_q_c5;
  logic                 w_na;

  assign w_na = ~a;

  sr_flop #(.HAS_SET(1'b0), .HAS_RST(1'b0), .SET_PRI(1'b1), .HAS_EN(1'b0)) u_c0 (
    .clk(clk), .rst_n(rst_n), .d(a), .s(1'b0), .r(1'b0), .en(1'b1), .q(w_q_c0));

  sr_flop #(.HAS_SET(1'b1), .HAS_RST(1'b0), .SET_PRI(1'b1), .HAS_EN(1'b0)) u_c1 (
    .clk(clk), .rst_n(rst_n), .d(r_a_q), .s(a), .r(1'b0), .en(1'b1), .q(w_q_c1));

  sr_flop #(.HAS_SET(1'b0), .HAS_RST(1'b1), .SET_PRI(1'b1), .HAS_EN(1'b0)) u_c2 (
    .clk(clk), .rst_n(rst_n), .d(a), .s(1'b0), .r(r_a_q), .en(1'b1), .q(w_q_c2));

  sr_flop #(.HAS_SET(1'b1), .HAS_RST(1'b1), .SET_PRI(1'b1), .HAS_EN(1'b0)) u_c3 (
    .clk(clk), .rst_n(rst_n), .d(w_na), .s(a), .r(r_a_q), .en(1'b1), .q(w_q_c3));

  sr_flop #(.HAS_SET(1'b1), .HAS_RST(1'b1), .SET_PRI(1'b0), .HAS_EN(1'b0)) u_c4 (
    .clk(clk), .rst_n(rst_n), .d(w_na), .s(a), .r(r_a_q), .en(1'b1), .q(w_q_c4));

  sr_flop #(.HAS_SET(1'b0), .HAS_RST(1'b0), .SET_PRI(1'b1), .HAS_EN(1'b1)) u_c5 (
    .clk(clk), .rst_n(rst_n), .d(a), .s(1'b0), .r(1'b0), .en(r_a_q), .q(w_q_c5));

  assign w_cell_q = {w_q_c5, w_q_c4, w_q_c3, w_q_c2, w_q_c1, w_q_c0};

  // Golden next state as a 4-entry truth table indexed by {a, a_q}; bit 3 is {1,1}.
  function automatic logic gold_next(input cell_kind_e kind, input logic a_s,
                                     input logic a_q_s, input logic q_s);
    logic [3:0] tt;
    logic [1:0] sel;
    sel = {a_s, a_q_s};
    tt  = 4'b0000;
    case (kind)
      K_PLAIN:     tt = 4'b1100;
      K_SET:       tt = 4'b1110;
      K_RST:       tt = 4'b0100;
      K_SR_SETPRI: tt = 4'b1101;
      K_SR_RSTPRI: tt = 4'b0101;
      K_EN:        tt = {1'b1, q_s, 1'b0, q_s};
      default:     tt = 4'b0000;
    endcase
    return tt[sel];
  endfunction

  always_comb begin
    w_gold_d              = '0;
    w_gold_d[C_PLAIN]     = gold_next(K_PLAIN,     a, r_a_q, r_gold[C_PLAIN]);
    w_gold_d[C_SET]       = gold_next(K_SET,       a, r_a_q, r_gold[C_SET]);
    w_gold_d[C_RST]       = gold_next(K_RST,       a, r_a_q, r_gold[C_RST]);
    w_gold_d[C_SR_SETPRI] = gold_next(K_SR_SETPRI, a, r_a_q, r_gold[C_SR_SETPRI]);
    w_gold_d[C_SR_RSTPRI] = gold_next(K_SR_RSTPRI, a, r_a_q, r_gold[C_SR_RSTPRI]);
    w_gold_d[C_EN]        = gold_next(K_EN,        a, r_a_q, r_gold[C_EN]);
  end

  assign w_match = (w_cell_q == r_gold);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a_q  <= 1'b0;
      r_gold <= '0;
      r_b    <= 1'b1;
    end else begin
      r_a_q  <= a;
      r_gold <= w_gold_d;
      r_b    <= w_match;
    end
  end

  assign b = r_b;

endmodule

// File: tb/tb_dffsr_top.sv
// Randomized bench for dffsr_top with a rule-level reference model of the six cells.
module tb_dffsr_top;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic a     = 1'b0;
  logic b;

  int n_chk  = 0;
  int n_pass = 0;

  bit tog_en = 1'b0;
  bit chk_en = 1'b0;
  bit inj    = 1'b0;
  bit forced = 1'b0;

  logic       m_aq = 1'b0;
  logic [5:0] m_q  = '0;
  logic       m_b  = 1'b1;

  dffsr_top dut (.clk(clk), .rst_n(rst_n), .a(a), .b(b));

  always #5 clk = ~clk;

  // Free-running toggler; skips toggles landing exactly on a rising edge.
  always begin
    #3;
    if (tog_en && (($time % 10) != 5)) a = ~a;
  end

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
  endtask

  function automatic logic ref_next(input int idx, input logic q, input logic av, input logic aqv);
    logic nq;
    case (idx)
      0:       nq = av;
      1:       nq = av ? 1'b1 : aqv;
      2:       nq = aqv ? 1'b0 : av;
      3:       nq = av ? 1'b1 : (aqv ? 1'b0 : ~av);
      4:       nq = aqv ? 1'b0 : (av ? 1'b1 : ~av);
      default: nq = aqv ? av : q;
    endcase
    return nq;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_aq <= 1'b0;
      m_q  <= '0;
      m_b  <= 1'b1;
    end else begin
      for (int i = 0; i < 6; i++) m_q[i] <= ref_next(i, m_q[i], a, m_aq);
      m_aq <= a;
      m_b  <= !inj;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [5:0] mask;
      mask = forced ? 6'b000100 : 6'b000000;
      check_eq("b", 8'(b), 8'(m_b));
      check_eq("a_q", 8'(dut.r_a_q), 8'(m_aq));
      check_eq("cells", 8'(dut.w_cell_q & ~mask), 8'(m_q & ~mask));
      check_eq("gold", 8'(dut.r_gold), 8'(m_q));
    end
  end

  initial begin
    tog_en = 1'b1;
    chk_en = 1'b1;
    rst_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_b", 8'(b), 8'd1);
    check_eq("rst_aq", 8'(dut.r_a_q), 8'd0);
    check_eq("rst_cells", 8'(dut.w_cell_q), 8'd0);

    @(negedge clk) rst_n = 1'b1;
    repeat (10000) @(posedge clk);

    // Mid-run reset while a keeps toggling.
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("mid_rst_b", 8'(b), 8'd1);
    check_eq("mid_rst_cells", 8'(dut.w_cell_q), 8'd0);
    check_eq("mid_rst_gold", 8'(dut.r_gold), 8'd0);
    check_eq("mid_rst_aq", 8'(dut.r_a_q), 8'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (50) @(posedge clk);

    // Simultaneous set and reset on c3/c4.
    tog_en = 1'b0;
    @(negedge clk) a = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("sr_c3", 8'(dut.w_cell_q[3]), 8'd1);
    check_eq("sr_c4", 8'(dut.w_cell_q[4]), 8'd0);
    check_eq("sr_b", 8'(b), 8'd1);
    check_eq("en_pre_c5", 8'(dut.w_cell_q[5]), 8'd1);

    // Enable cell captures 0 once, then holds.
    @(negedge clk) a = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check_eq("en_c5", 8'(dut.w_cell_q[5]), 8'd0);
      check_eq("en_b", 8'(b), 8'd1);
    end

    // Fault injection on c2 while a_q=1 and golden c2=0.
    @(negedge clk) a = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("inj_pre_b", 8'(b), 8'd1);
    inj    = 1'b1;
    forced = 1'b1;
    force dut.w_q_c2 = 1'b1;
    @(posedge clk);
    #1;
    check_eq("inj_b", 8'(b), 8'd0);
    release dut.w_q_c2;
    inj    = 1'b0;
    forced = 1'b0;
    @(posedge clk);
    #1;
    check_eq("inj_post_b", 8'(b), 8'd1);

    // Random stimulus: several changes per cycle, occasional reset pulses.
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 49) != 0);
      a = 1'($urandom);
      #2 a = 1'($urandom);
      #1 a = 1'($urandom);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
